// File: rtl/spi_reg_master_if_if.sv
`default_nettype none
// =============================================================================
//  Module      : spi_reg_master_if_if
//  Description : Parallel register-bank bus carried between the SPI front end
//                and the Register8 bank (write strobe, read strobe, data).
//  Revision    : 1.0  initial release
// =============================================================================
interface spi_reg_master_if_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              stb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rd_stb;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output stb,
        output addr,
        output data,
        output rd_stb,
        input  rd_data
    );

    modport slave (
        input  stb,
        input  addr,
        input  data,
        input  rd_stb,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_master_if.sv
`default_nettype none
// =============================================================================
//  Module      : spi_reg_master_if
//  Description : SPI mode-0 slave that decodes 16-bit host frames into register
//                bank writes (stb) or reads (rd_stb, byte returned on miso).
//  Revision    : 1.0  initial release
// =============================================================================
module spi_reg_master_if #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 sck,
    input  wire logic                 ss_n,
    input  wire logic                 mosi,
    output logic                      miso,
    output logic                      miso_oe,
    output logic                      busy,
    spi_reg_master_if_if.master       bus
);

    localparam int HDR_W   = ADDR_W + 1;
    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_LOAD = 3'd3,
        S_RD_DATA = 3'd4,
        S_WR_DATA = 3'd5,
        S_WR_STB  = 3'd6,
        S_HOLD    = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_armed;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic [ADDR_W-1:0]      r_hdr;
    logic [DATA_W-2:0]      r_dsh;
    logic [DATA_W-1:0]      r_tx;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic                   r_miso;

    logic              w_sck_s;
    logic              w_ss_s;
    logic              w_mosi_s;
    logic              w_rise;
    logic              w_fall;
    logic              w_sel;
    logic              w_shift_en;
    logic              w_stb;
    logic              w_rd_stb;
    logic [ADDR_W:0]   w_hdr_nxt;
    logic [DATA_W-1:0] w_dat_nxt;

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sck_s & ~r_sck_d;
    assign w_fall   = ~w_sck_s & r_sck_d;

    // r_armed only sets once select has been seen high, so a frame cut by
    // reset is drained (ignored) until the host releases SS_N.
    assign w_sel = r_armed & ~w_ss_s;

    assign w_hdr_nxt = {r_hdr, w_mosi_s};
    assign w_dat_nxt = {r_dsh, w_mosi_s};

    always_comb begin
        w_shift_en = 1'b0;
        case (r_state)
            S_IDLE, S_HDR, S_WR_DATA, S_RD_DATA: w_shift_en = w_rise & w_sel;
            default:                             w_shift_en = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_stb       = 1'b0;
        w_rd_stb    = 1'b0;

        case (r_state)
            S_WR_STB: w_stb    = 1'b1;
            S_RD_REQ: w_rd_stb = 1'b1;
            default:  ;
        endcase

        if (r_state != S_IDLE && w_ss_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel) begin
                        w_state_nxt = S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_shift_en && r_cnt == HDR_LAST) begin
                        w_state_nxt = w_hdr_nxt[ADDR_W] ? S_RD_REQ : S_WR_DATA;
                    end
                end
                S_RD_REQ:  w_state_nxt = S_RD_LOAD;
                S_RD_LOAD: w_state_nxt = S_RD_DATA;
                S_RD_DATA: begin
                    if (w_shift_en && r_cnt == FRAME_LAST) begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_WR_DATA: begin
                    if (w_shift_en && r_cnt == FRAME_LAST) begin
                        w_state_nxt = S_WR_STB;
                    end
                end
                S_WR_STB:  w_state_nxt = S_HOLD;
                S_HOLD:    w_state_nxt = S_HOLD;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Synchronisers, shift registers and registered bus outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hdr       <= '0;
            r_dsh       <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_miso      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck_s;
            r_armed     <= r_armed | w_ss_s;

            if (w_state_nxt == S_IDLE) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else if (w_shift_en) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_busy <= 1'b1;
            end

            if (w_shift_en && (r_state == S_IDLE || r_state == S_HDR)) begin
                r_hdr <= w_hdr_nxt[ADDR_W-1:0];
            end

            // Reads publish the address with rd_stb; writes wait for the full
            // frame so an aborted write leaves addr/data untouched.
            if (w_shift_en && r_state == S_HDR && r_cnt == HDR_LAST && w_hdr_nxt[ADDR_W]) begin
                r_addr <= w_hdr_nxt[ADDR_W-1:0];
            end

            if (w_shift_en && r_state == S_WR_DATA) begin
                r_dsh <= w_dat_nxt[DATA_W-2:0];
                if (r_cnt == FRAME_LAST) begin
                    r_addr <= r_hdr;
                    r_data <= w_dat_nxt;
                end
            end

            if (r_state == S_RD_LOAD) begin
                r_tx <= bus.rd_data;
            end else if (r_state == S_RD_DATA && w_fall) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end

            // MISO keeps the last bit through HOLD and clears when the frame ends.
            if (w_state_nxt == S_IDLE) begin
                r_miso <= 1'b0;
            end else if (r_state == S_RD_DATA && w_fall) begin
                r_miso <= r_tx[DATA_W-1];
            end
        end
    end

    assign bus.stb    = w_stb;
    assign bus.rd_stb = w_rd_stb;
    assign bus.addr   = r_addr;
    assign bus.data   = r_data;
    assign miso       = r_miso;
    assign miso_oe    = w_sel;
    assign busy       = r_busy;

endmodule
`default_nettype wire
